// File: rtl/sparse_mult_pkg.sv
// sparse_mult_pkg: lane geometry, pass length, default column mask and FSM states.
// Shared by sparse_mult_by_A and sparse_mult_by_at.
package sparse_mult_pkg;
  localparam int LANE_WIDTH = 32;
  localparam int NUM_LANES = 3;
  localparam int A_LEN = 11;
  localparam logic [A_LEN-1:0] DEFAULT_COL_MASK = 11'b100_0000_0000;
  typedef logic [LANE_WIDTH-1:0] lane_word_t;
  typedef enum logic {IDLE, EMIT} at_state_t;
  function automatic logic [NUM_LANES*LANE_WIDTH-1:0] pack_lanes(input lane_word_t l2, input lane_word_t l1, input lane_word_t l0);
    return {l2, l1, l0};
  endfunction
endpackage

// File: rtl/sparse_skid_buffer.sv
// sparse_skid_buffer: one-entry holding register that parks a word accepted while a pass is still running.
module sparse_skid_buffer #(
  parameter int WIDTH = 96
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);
  import sparse_mult_pkg::*;
  logic full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    full_d = i_push || (full_q && !i_pop);
    data_d = i_push ? i_data : data_q;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign o_data = data_q;
  assign o_full = full_q;
endmodule

// File: rtl/sparse_mult_by_at.sv
// sparse_mult_by_at: multiplies one packed word by A^T, emitting an A_LEN-beat pass (beat k = word if COL_MASK[k]).
// SPARSE_MULT_AT_SKID_EN adds a one-entry input skid so back-to-back passes run without a bubble.
module sparse_mult_by_at #(
  parameter int WIDTH = sparse_mult_pkg::LANE_WIDTH * sparse_mult_pkg::NUM_LANES,
  parameter int A_LEN = sparse_mult_pkg::A_LEN,
  parameter logic [A_LEN-1:0] COL_MASK = sparse_mult_pkg::DEFAULT_COL_MASK
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_input_data,
  input  logic             i_input_valid,
  output logic             o_input_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_output_valid,
  input  logic             i_output_ready,
  output logic             o_output_last
);
  import sparse_mult_pkg::*;
  localparam int CW = (A_LEN > 1) ? $clog2(A_LEN) : 1;
  at_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic ready_q, ready_d;
  logic in_xfer, out_xfer, beat_last, pass_done, refill;
  logic [WIDTH-1:0] refill_data;
  assign in_xfer = i_input_valid && ready_q;
  assign beat_last = cnt_q == CW'(A_LEN - 1);
  assign out_xfer = (state_q == EMIT) && i_output_ready;
  assign pass_done = out_xfer && beat_last;
`ifdef SPARSE_MULT_AT_SKID_EN
  logic skid_push, skid_pop, skid_full;
  logic [WIDTH-1:0] skid_data;
  // Ready is registered as !full, so an accepted word always finds the skid empty.
  assign skid_push = in_xfer && (state_q == EMIT) && !pass_done;
  assign skid_pop = pass_done && skid_full;
  assign refill = pass_done && (skid_full || in_xfer);
  assign refill_data = skid_full ? skid_data : i_input_data;
  sparse_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_push (skid_push),
    .i_pop  (skid_pop),
    .i_data (i_input_data),
    .o_data (skid_data),
    .o_full (skid_full)
  );
`else
  assign refill = 1'b0;
  assign refill_data = i_input_data;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    if (state_q == IDLE && in_xfer) begin
      state_d = EMIT;
      cnt_d = '0;
      hold_d = i_input_data;
    end else if (pass_done) begin
      state_d = refill ? EMIT : IDLE;
      cnt_d = '0;
      hold_d = refill ? refill_data : hold_q;
    end else if (out_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef SPARSE_MULT_AT_SKID_EN
    ready_d = !(skid_push || (skid_full && !skid_pop));
`else
    ready_d = state_d == IDLE;
`endif
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      ready_q <= ready_d;
    end
  end
  assign o_input_ready = ready_q;
  assign o_output_valid = state_q == EMIT;
  assign o_output_data = (o_output_valid && COL_MASK[cnt_q]) ? hold_q : '0;
  assign o_output_last = o_output_valid && beat_last;
endmodule

// File: tb/tb_sparse_mult_by_at.sv
// tb_sparse_mult_by_at: table-driven and randomized check of sparse_mult_by_at against a queue-based expansion model.
module tb_sparse_mult_by_at;
  import sparse_mult_pkg::*;
  localparam int W = LANE_WIDTH * NUM_LANES;
  localparam logic [A_LEN-1:0] MASK = DEFAULT_COL_MASK;
`ifdef SPARSE_MULT_AT_SKID_EN
  localparam int EXP_GAPS = 0;
`else
  localparam int EXP_GAPS = 4;
`endif
  typedef struct {
    logic [W-1:0] d;
    logic l;
  } beat_t;
  typedef struct {
    logic [W-1:0] word;
    bit toggle;
    logic [W-1:0] exp_last_data;
    int exp_beats;
  } vec_t;
  logic i_clock = 1'b0, i_reset = 1'b1, i_input_valid = 1'b0, i_output_ready = 1'b0;
  logic [W-1:0] i_input_data = '0;
  logic o_input_ready, o_output_valid, o_output_last;
  logic [W-1:0] o_output_data;
  int n_vec = 0, n_err = 0, n_out = 0, cyc = 0, gaps = 0, acc_cyc = 0, fv_cyc = 0, pb = 0, mode = 0;
  bit seen_valid = 0, prev_stall = 0;
  logic [W-1:0] prev_data = '0, last_data = '0;
  logic prev_last = 1'b0;
  logic [W-1:0] in_q[$], rt_q[$];
  beat_t exp_q[$];
  logic [LANE_WIDTH-1:0] acc[NUM_LANES];
  vec_t tbl[5];

  sparse_mult_by_at dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_input_data(i_input_data),
    .i_input_valid(i_input_valid),
    .o_input_ready(o_input_ready),
    .o_output_data(o_output_data),
    .o_output_valid(o_output_valid),
    .i_output_ready(i_output_ready),
    .o_output_last(o_output_last)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    rt_q.delete();
    in_q.delete();
    pb = 0;
    prev_stall = 0;
    for (int j = 0; j < NUM_LANES; j++) acc[j] = '0;
  endtask

  // One clock: drive at the falling edge, sample 1ns later, score what the next rising edge transfers.
  task automatic step();
    beat_t b;
    logic [W-1:0] w;
    @(negedge i_clock);
    i_input_valid = in_q.size() > 0;
    i_input_data = i_input_valid ? in_q[0] : '0;
    i_output_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !i_output_ready : 1'($urandom_range(0, 1));
    #1;
    cyc++;
    if (prev_stall) begin
      chk("stall_data", o_output_data, prev_data);
      chk("stall_last", {{(W-1){1'b0}}, o_output_last}, {{(W-1){1'b0}}, prev_last});
    end
    if (o_output_valid === 1'b1) begin
      if (!seen_valid) fv_cyc = cyc;
      seen_valid = 1;
    end else if (seen_valid && (in_q.size() > 0 || exp_q.size() > 0)) gaps++;
`ifndef SPARSE_MULT_AT_SKID_EN
    if (o_output_valid === 1'b1) chk("ready_in_pass", {{(W-1){1'b0}}, o_input_ready}, '0);
`endif
    if (o_output_valid === 1'b1 && i_output_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_beat", o_output_data, '1 ^ o_output_data);
      else begin
        b = exp_q.pop_front();
        chk("beat_data", o_output_data, b.d);
        chk("beat_last", {{(W-1){1'b0}}, o_output_last}, {{(W-1){1'b0}}, b.l});
      end
      if (pb < A_LEN && MASK[pb])
        for (int j = 0; j < NUM_LANES; j++) acc[j] = acc[j] + o_output_data[j*LANE_WIDTH +: LANE_WIDTH];
      pb++;
      if (o_output_last === 1'b1) begin
        last_data = o_output_data;
        if (rt_q.size() > 0) chk("round_trip", {acc[2], acc[1], acc[0]}, rt_q.pop_front());
        pb = 0;
        for (int j = 0; j < NUM_LANES; j++) acc[j] = '0;
      end
    end
    if (i_input_valid && o_input_ready === 1'b1) begin
      w = in_q.pop_front();
      rt_q.push_back(w);
      acc_cyc = cyc;
      for (int k = 0; k < A_LEN; k++) begin
        b.d = MASK[k] ? w : '0;
        b.l = (k == A_LEN - 1);
        exp_q.push_back(b);
      end
    end
    prev_stall = (o_output_valid === 1'b1) && !i_output_ready;
    prev_data = o_output_data;
    prev_last = o_output_last;
  endtask

  task automatic drain(input int bound);
    for (int c = 0; c < bound && (in_q.size() > 0 || exp_q.size() > 0); c++) step();
    chk("drain_pending", W'(in_q.size() + exp_q.size()), '0);
  endtask

  initial begin
    tbl[0] = '{'0, 1'b0, '0, 11};
    tbl[1] = '{pack_lanes(67108896, 65536, 134217792), 1'b0, pack_lanes(67108896, 65536, 134217792), 11};
    tbl[2] = '{pack_lanes(96, 65535, 69696969), 1'b1, pack_lanes(96, 65535, 69696969), 11};
    tbl[3] = '{'1, 1'b1, '1, 11};
    tbl[4] = '{pack_lanes(32'h8000_0000, 0, 1), 1'b0, pack_lanes(32'h8000_0000, 0, 1), 11};
    flush();
    mode = 0;
    repeat (3) step();
    chk("rst_valid", {{(W-1){1'b0}}, o_output_valid}, '0);
    chk("rst_data", o_output_data, '0);
    chk("rst_last", {{(W-1){1'b0}}, o_output_last}, '0);
    chk("rst_ready", {{(W-1){1'b0}}, o_input_ready}, '0);
    i_reset = 1'b0;
    step();
    step();
    chk("ready_after_reset", {{(W-1){1'b0}}, o_input_ready}, W'(1));
    n_out = 0;
    repeat (100) step();
    chk("idle_transfers", W'(n_out), '0);
    chk("idle_ready", {{(W-1){1'b0}}, o_input_ready}, W'(1));
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].toggle ? 1 : 0;
      n_out = 0;
      seen_valid = 0;
      last_data = ~tbl[i].exp_last_data;
      in_q.push_back(tbl[i].word);
      drain(300);
      chk("pass_beats", W'(n_out), W'(tbl[i].exp_beats));
      chk("pass_last_data", last_data, tbl[i].exp_last_data);
      chk("first_valid_latency", W'(fv_cyc - acc_cyc), W'(1));
      mode = 0;
      repeat (3) step();
    end
    mode = 0;
    n_out = 0;
    gaps = 0;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) in_q.push_back(pack_lanes(32'(i * 7 + 1), 32'hdead_0000 + 32'(i), 32'(1 << i)));
    drain(300);
    chk("stream_beats", W'(n_out), W'(55));
    chk("stream_gaps", W'(gaps), W'(EXP_GAPS));
    mode = 2;
    n_out = 0;
    for (int i = 0; i < 20; i++)
      in_q.push_back(pack_lanes($urandom_range(0, 3) == 0 ? 32'd0 : $urandom, $urandom, $urandom_range(0, 1) ? 32'hffff_ffff : $urandom));
    drain(3000);
    chk("random_beats", W'(n_out), W'(220));
    mode = 0;
    repeat (3) step();
    in_q.push_back(pack_lanes(32'h1111_2222, 32'h3333_4444, 32'h5555_6666));
    for (int c = 0; c < 50 && pb < 6; c++) step();
    chk("reached_beat5", W'(pb), W'(6));
    i_reset = 1'b1;
    step();
    chk("valid_after_reset", {{(W-1){1'b0}}, o_output_valid}, '0);
    chk("ready_during_reset", {{(W-1){1'b0}}, o_input_ready}, '0);
    flush();
    step();
    i_reset = 1'b0;
    step();
    step();
    n_out = 0;
    in_q.push_back(pack_lanes(32'h0bad_cafe, 32'h1234_5678, 32'h9abc_def0));
    drain(100);
    chk("restart_beats", W'(n_out), W'(11));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
